// File: rtl/xcorr_peak_finder.sv
// Sequential peak search over one captured correlation vector, one lag per clock.
// Define XCORR_PEAK_ABS_EN to rank lags by saturated magnitude instead of signed value.
module xcorr_peak_finder #(
  parameter int N_LAGS = 7,
  parameter int WIDTH  = 32,
  parameter int CENTER = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     corr [N_LAGS],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(N_LAGS)-1:0]   peak_idx,
  output logic signed [WIDTH-1:0]     peak_val,
  output logic signed [3:0]           lag,
  output logic                        peak_unique
);

  localparam int IW = $clog2(N_LAGS);
  localparam logic [IW-1:0] LAST = IW'(N_LAGS - 1);
  localparam logic signed [3:0] CTR = 4'(CENTER);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]              state;
  logic signed [WIDTH-1:0] vec [N_LAGS];
  logic signed [WIDTH-1:0] best_val;
  logic [IW-1:0]           best_idx;
  logic                    tie;
  logic [IW-1:0]           i;

  logic signed [WIDTH-1:0] cand;
  logic signed [WIDTH-1:0] nval;
  logic [IW-1:0]           nidx;
  logic                    ntie;

  function automatic logic signed [WIDTH-1:0] key(
    input logic signed [WIDTH-1:0] x
  );
`ifdef XCORR_PEAK_ABS_EN
    // |most-negative| does not fit, so it saturates to the largest positive
    if (x == {1'b1, {(WIDTH-1){1'b0}}})
      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (x < 0)
      return -x;
    else
      return x;
`else
    return x;
`endif
  endfunction

  assign in_ready  = reset_n && (state == IDLE);
  assign out_valid = (state == HOLD);

  always_comb begin
    cand = vec[i];
    nval = best_val;
    nidx = best_idx;
    ntie = tie;
    if (key(cand) > key(best_val)) begin
      nval = cand;
      nidx = i;
      ntie = 1'b0;
    end else if (key(cand) == key(best_val)) begin
      ntie = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      peak_idx    <= '0;
      peak_val    <= '0;
      lag         <= '0;
      peak_unique <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            vec      <= corr;
            best_val <= corr[0];
            best_idx <= '0;
            tie      <= 1'b0;
            i        <= IW'(1);
            state    <= SCAN;
          end
        end
        SCAN: begin
          best_val <= nval;
          best_idx <= nidx;
          tie      <= ntie;
          i        <= i + 1'b1;
          if (i == LAST) begin
            peak_idx    <= nidx;
            peak_val    <= nval;
            lag         <= 4'(nidx) - CTR;
            peak_unique <= ~ntie;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// Randomized self-checking bench for xcorr_peak_finder.
// Reference model ranks lags directly from the captured vector.
module tb_xcorr_peak_finder;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] corr [7];
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         peak_idx;
  logic signed [31:0] peak_val;
  logic signed [3:0]  lag;
  logic               peak_unique;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xcorr_peak_finder dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .corr(corr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .peak_idx(peak_idx),
    .peak_val(peak_val),
    .lag(lag),
    .peak_unique(peak_unique)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint rank(input logic signed [31:0] x);
    longint v;
    v = longint'(x);
`ifdef XCORR_PEAK_ABS_EN
    if (v < 0) v = -v;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
`endif
    return v;
  endfunction

  // Peak = first index holding the maximum rank; unique if only one does.
  task automatic model(input logic signed [31:0] v [7], output int idx,
                       output logic uniq);
    longint mx;
    int cnt;
    mx = rank(v[0]);
    for (int k = 1; k < 7; k++)
      if (rank(v[k]) > mx) mx = rank(v[k]);
    idx = -1;
    cnt = 0;
    for (int k = 0; k < 7; k++)
      if (rank(v[k]) == mx) begin
        if (idx < 0) idx = k;
        cnt++;
      end
    uniq = (cnt == 1);
  endtask

  function automatic logic signed [31:0] rnd_word(input int mode);
    logic signed [31:0] w;
    case (mode)
      0: w = 32'($signed($urandom_range(0, 8)) - 4);
      1: w = 32'($urandom);
      default: begin
        case ($urandom_range(0, 3))
          0: w = 32'h8000_0000;
          1: w = 32'h7fff_ffff;
          2: w = 32'h8000_0001;
          default: w = 32'h0;
        endcase
      end
    endcase
    return w;
  endfunction

  task automatic run_vec(input logic signed [31:0] v [7], input int hold,
                         input string tag);
    int eidx;
    logic euniq;
    int k;
    logic [2:0] s_idx;
    logic [31:0] s_val;
    logic [3:0] s_lag;
    logic s_uniq;
    model(v, eidx, euniq);
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    corr = v;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      in_valid = 1'($urandom);
      for (int j = 0; j < 7; j++) corr[j] = 32'($urandom);
      if (!out_valid && in_ready) begin
        check({tag, ".scan_ready"}, 32'(in_ready), 32'd0);
      end
    end while (!out_valid && k < 20);
    check({tag, ".latency"}, 32'(k), 32'd7);
    check({tag, ".peak_idx"}, 32'(peak_idx), 32'(eidx));
    check({tag, ".peak_val"}, peak_val, v[eidx]);
    check({tag, ".lag"}, 32'(lag), 32'(4'(eidx - 3)));
    check({tag, ".unique"}, 32'(peak_unique), 32'(euniq));
    s_idx = peak_idx;
    s_val = peak_val;
    s_lag = lag;
    s_uniq = peak_unique;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      for (int j = 0; j < 7; j++) corr[j] = 32'($urandom);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_stable"},
            {s_val[23:0], s_idx, s_lag, s_uniq},
            {peak_val[23:0], peak_idx, lag, peak_unique});
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".done_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  logic signed [31:0] v [7];

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int j = 0; j < 7; j++) corr[j] = '0;
    #2;
    check("rst.in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.outs", {peak_val[27:0], 1'b0, peak_idx},
          32'd0);
    check("rst.lag_unique", {27'd0, lag, peak_unique}, 32'd0);

    v = '{32'sd5, 32'sd9, -32'sd3, 32'sd40, 32'sd12, 32'sd40, 32'sd1};
    run_vec(v, 0, "tie40");
    v = '{-32'sd100, -32'sd7, -32'sd50, -32'sd8, -32'sd9, -32'sd60, -32'sd70};
    run_vec(v, 0, "neg");
    v = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd3, 32'sd2, 32'sd1};
    run_vec(v, 5, "hold5");

    // Reset in the middle of a scan abandons the vector.
    @(negedge clk);
    corr = v;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) check("rstscan.no_valid", 32'(out_valid), 32'd0);
    end
    check("rstscan.idle", 32'(in_ready), 32'd1);
    v = '{0, 0, 0, 0, 0, 0, 32'sd77};
    run_vec(v, 0, "last77");

    v = '{32'sd10, 32'sh8000_0000, 32'sh7fff_ffff, 0, 0, 0, 0};
    run_vec(v, 1, "extreme");
    for (int j = 0; j < 7; j++) v[j] = 32'sh8000_0000;
    run_vec(v, 0, "allmin");
    for (int j = 0; j < 7; j++) v[j] = 32'sd17;
    run_vec(v, 0, "alleq");

    for (int n = 0; n < 40; n++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int j = 0; j < 7; j++) v[j] = rnd_word(mode);
      run_vec(v, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
